uart_word_rx: RTL and testbench

- 8N1 UART receiver that turns serial bytes into 32-bit words for the core.
- Built-in synchronizer and mid-bit sampling; bytes are packed into a 32-bit word, little-endian.
- Completed word is offered on a valid/ready handshake with a one-word holding register.
- Receive-side counterpart to the word transmitter feeding uart_tx; it sits beside it in the UART top level and drives the core's rx_word input.

---
 rtl/uart_word_rx.sv | 167 ++++++++++++++++
 tb/tb_uart_word_rx.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_word_rx.sv
// rtl/uart_word_rx.sv - 8N1 UART receiver packing bytes into little-endian 32-bit words
module uart_word_rx #(
   parameter int CLKS_PER_BIT = 234,
   parameter int TIMEOUT_BITS = 20
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        uart_rx,
   output logic [31:0] word_data,
   output logic        word_valid,
   input  logic        word_ready,
   output logic        frame_err,
   output logic        overrun,
   output logic [1:0]  byte_cnt
);

   localparam int CNT_W    = $clog2(CLKS_PER_BIT);
   localparam int TO_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
   localparam int TO_W     = $clog2(TO_LIMIT);

   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'((CLKS_PER_BIT - 1) / 2);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TO_LIMIT - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      WAIT_IDLE
   } state_t;

   state_t            state, state_n;
   logic              rx_meta, rx_s;
   logic [CNT_W-1:0]  clk_cnt, clk_cnt_n;
   logic [2:0]        bit_idx, bit_idx_n;
   logic [7:0]        shift, shift_n;
   logic [23:0]       asm_word, asm_word_n;
   logic [TO_W-1:0]   to_cnt, to_cnt_n;
   logic [1:0]        byte_cnt_n;
   logic [31:0]       word_data_n;
   logic              word_valid_n;
   logic              frame_err_n;
   logic              overrun_n;

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_meta    <= 1'b1;
         rx_s       <= 1'b1;
         state      <= IDLE;
         clk_cnt    <= '0;
         bit_idx    <= '0;
         shift      <= '0;
         asm_word   <= '0;
         to_cnt     <= '0;
         byte_cnt   <= '0;
         word_data  <= '0;
         word_valid <= 1'b0;
         frame_err  <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         rx_meta    <= uart_rx;
         rx_s       <= rx_meta;
         state      <= state_n;
         clk_cnt    <= clk_cnt_n;
         bit_idx    <= bit_idx_n;
         shift      <= shift_n;
         asm_word   <= asm_word_n;
         to_cnt     <= to_cnt_n;
         byte_cnt   <= byte_cnt_n;
         word_data  <= word_data_n;
         word_valid <= word_valid_n;
         frame_err  <= frame_err_n;
         overrun    <= overrun_n;
      end
   end

   always_comb begin
      state_n      = state;
      clk_cnt_n    = clk_cnt;
      bit_idx_n    = bit_idx;
      shift_n      = shift;
      asm_word_n   = asm_word;
      to_cnt_n     = '0;
      byte_cnt_n   = byte_cnt;
      word_data_n  = word_data;
      word_valid_n = word_valid && !word_ready;
      frame_err_n  = 1'b0;
      overrun_n    = 1'b0;

      case (state)
         IDLE: begin
            // Partial words age out silently if the sender stalls mid-word.
            if (byte_cnt != 2'd0) begin
               if (to_cnt == TO_LAST) begin
                  byte_cnt_n = 2'd0;
               end else begin
                  to_cnt_n = to_cnt + TO_W'(1);
               end
            end
            if (!rx_s) begin
               state_n   = START;
               clk_cnt_n = '0;
               to_cnt_n  = '0;
            end
         end
         START: begin
            if (clk_cnt == CNT_HALF) begin
               clk_cnt_n = '0;
               bit_idx_n = '0;
               state_n   = rx_s ? IDLE : DATA;
            end else begin
               clk_cnt_n = clk_cnt + CNT_W'(1);
            end
         end
         DATA: begin
            if (clk_cnt == CNT_LAST) begin
               clk_cnt_n = '0;
               shift_n   = {rx_s, shift[7:1]};
               if (bit_idx == 3'd7) begin
                  state_n = STOP;
               end else begin
                  bit_idx_n = bit_idx + 3'd1;
               end
            end else begin
               clk_cnt_n = clk_cnt + CNT_W'(1);
            end
         end
         STOP: begin
            if (clk_cnt == CNT_LAST) begin
               clk_cnt_n = '0;
               if (rx_s) begin
                  state_n    = IDLE;
                  byte_cnt_n = byte_cnt + 2'd1;
                  case (byte_cnt)
                     2'd0: asm_word_n[7:0]   = shift;
                     2'd1: asm_word_n[15:8]  = shift;
                     2'd2: asm_word_n[23:16] = shift;
                     default: begin
                        // The holding register frees up in the same cycle it is consumed.
                        if (!word_valid || word_ready) begin
                           word_data_n  = {shift, asm_word};
                           word_valid_n = 1'b1;
                        end else begin
                           overrun_n = 1'b1;
                        end
                     end
                  endcase
               end else begin
                  state_n     = WAIT_IDLE;
                  frame_err_n = 1'b1;
                  byte_cnt_n  = 2'd0;
               end
            end else begin
               clk_cnt_n = clk_cnt + CNT_W'(1);
            end
         end
         WAIT_IDLE: begin
            if (rx_s) begin
               state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

endmodule

// File: tb/tb_uart_word_rx.sv
// tb/tb_uart_word_rx.sv - directed self-checking bench for uart_word_rx
module tb_uart_word_rx;

   localparam int CPB = 16;
   localparam int TOB = 20;
   // Start drive -> stop sample: 2 sync flops, 1 IDLE decision, half bit + 1, 9 full bits.
   localparam int STOP_LAT = 3 + (CPB - 1) / 2 + 1 + 9 * CPB;

   logic        clk;
   logic        rst;
   logic        uart_rx;
   logic [31:0] word_data;
   logic        word_valid;
   logic        word_ready;
   logic        frame_err;
   logic        overrun;
   logic [1:0]  byte_cnt;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int fe_cnt = 0;
   int ov_cnt = 0;
   int ov_cyc = 0;
   int rise_cyc = 0;
   int start_cyc = 0;
   logic wv_prev = 1'b0;

   uart_word_rx #(.CLKS_PER_BIT(CPB), .TIMEOUT_BITS(TOB)) dut (
      .clk        (clk),
      .rst        (rst),
      .uart_rx    (uart_rx),
      .word_data  (word_data),
      .word_valid (word_valid),
      .word_ready (word_ready),
      .frame_err  (frame_err),
      .overrun    (overrun),
      .byte_cnt   (byte_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      #1;
      if (frame_err) fe_cnt = fe_cnt + 1;
      if (overrun) begin
         ov_cnt = ov_cnt + 1;
         ov_cyc = cyc;
      end
      if (word_valid && !wv_prev) rise_cyc = cyc;
      wv_prev = word_valid;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total = total + 1;
      if (got !== exp) begin
         bad = bad + 1;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic wait_clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop_bit);
      @(negedge clk);
      start_cyc = cyc;
      uart_rx = 1'b0;
      wait_clks(CPB - 1);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         uart_rx = b[i];
         wait_clks(CPB - 1);
      end
      @(negedge clk);
      uart_rx = stop_bit;
      wait_clks(CPB - 1);
   endtask

   task automatic consume();
      @(negedge clk);
      word_ready = 1'b1;
      @(negedge clk);
      word_ready = 1'b0;
   endtask

   initial begin
      int fe0, ov0;
      rst = 1'b1;
      uart_rx = 1'b1;
      word_ready = 1'b0;
      wait_clks(3);
      chk("rst_valid", {31'd0, word_valid}, 32'd0);
      chk("rst_data", word_data, 32'd0);
      chk("rst_bytecnt", {30'd0, byte_cnt}, 32'd0);
      chk("rst_pulses", {30'd0, frame_err, overrun}, 32'd0);
      rst = 1'b0;
      wait_clks(4);

      // 1: basic word, hold, handshake
      send_byte(8'h78, 1'b1);
      chk("t1_bytecnt1", {30'd0, byte_cnt}, 32'd1);
      send_byte(8'h56, 1'b1);
      send_byte(8'h34, 1'b1);
      send_byte(8'h12, 1'b1);
      chk("t1_valid", {31'd0, word_valid}, 32'd1);
      chk("t1_data", word_data, 32'h12345678);
      chk("t1_latency", rise_cyc - start_cyc, STOP_LAT);
      chk("t1_bytecnt_wrap", {30'd0, byte_cnt}, 32'd0);
      wait_clks(100);
      chk("t1_hold_valid", {31'd0, word_valid}, 32'd1);
      chk("t1_hold_data", word_data, 32'h12345678);
      consume();
      chk("t1_released", {31'd0, word_valid}, 32'd0);

      // 2: framing error then a clean word
      fe0 = fe_cnt;
      send_byte(8'h11, 1'b1);
      send_byte(8'h22, 1'b0);
      @(negedge clk);
      uart_rx = 1'b1;
      wait_clks(2 * CPB);
      chk("t2_fe_count", fe_cnt - fe0, 32'd1);
      chk("t2_bytecnt", {30'd0, byte_cnt}, 32'd0);
      chk("t2_no_word", {31'd0, word_valid}, 32'd0);
      send_byte(8'h01, 1'b1);
      send_byte(8'h02, 1'b1);
      send_byte(8'h03, 1'b1);
      send_byte(8'h04, 1'b1);
      chk("t2_data", word_data, 32'h04030201);
      chk("t2_valid", {31'd0, word_valid}, 32'd1);
      consume();

      // 3: short low glitch is rejected
      fe0 = fe_cnt;
      ov0 = ov_cnt;
      @(negedge clk);
      uart_rx = 1'b0;
      wait_clks(4);
      uart_rx = 1'b1;
      wait_clks(3 * CPB);
      chk("t3_bytecnt", {30'd0, byte_cnt}, 32'd0);
      chk("t3_no_word", {31'd0, word_valid}, 32'd0);
      chk("t3_no_pulses", (fe_cnt - fe0) + (ov_cnt - ov0), 32'd0);

      // 4: overrun keeps the first word
      ov0 = ov_cnt;
      send_byte(8'h03, 1'b1);
      send_byte(8'h02, 1'b1);
      send_byte(8'h01, 1'b1);
      send_byte(8'h00, 1'b1);
      send_byte(8'h0D, 1'b1);
      send_byte(8'h0C, 1'b1);
      send_byte(8'h0B, 1'b1);
      send_byte(8'h0A, 1'b1);
      chk("t4_data", word_data, 32'h00010203);
      chk("t4_valid", {31'd0, word_valid}, 32'd1);
      chk("t4_ov_count", ov_cnt - ov0, 32'd1);
      chk("t4_ov_time", ov_cyc - start_cyc, STOP_LAT);
      consume();

      // 5: idle timeout drops partial word
      send_byte(8'h55, 1'b1);
      send_byte(8'h66, 1'b1);
      chk("t5_partial", {30'd0, byte_cnt}, 32'd2);
      wait_clks(21 * CPB);
      chk("t5_timeout", {30'd0, byte_cnt}, 32'd0);
      send_byte(8'hAA, 1'b1);
      send_byte(8'hBB, 1'b1);
      send_byte(8'hCC, 1'b1);
      send_byte(8'hDD, 1'b1);
      chk("t5_data", word_data, 32'hDDCCBBAA);
      chk("t5_valid", {31'd0, word_valid}, 32'd1);

      // 6: reset mid-frame, leaving word_valid set beforehand
      send_byte(8'h0D, 1'b1);
      @(negedge clk);
      uart_rx = 1'b0;
      wait_clks(4 * CPB - 1);
      @(negedge clk);
      rst = 1'b1;
      uart_rx = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("t6_rst_valid", {31'd0, word_valid}, 32'd0);
      chk("t6_rst_data", word_data, 32'd0);
      chk("t6_rst_bytecnt", {30'd0, byte_cnt}, 32'd0);
      chk("t6_rst_pulses", {30'd0, frame_err, overrun}, 32'd0);
      wait_clks(2 * CPB);
      send_byte(8'h0D, 1'b1);
      send_byte(8'hF0, 1'b1);
      send_byte(8'hFE, 1'b1);
      send_byte(8'hCA, 1'b1);
      chk("t6_data", word_data, 32'hCAFEF00D);
      chk("t6_valid", {31'd0, word_valid}, 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
